bus_tx_framer: RTL and testbench

// Upstream send-side stage for the shared-bus interface block. Buffers payload bytes in a FIFO,

---
 rtl/bus_tx_framer_if.sv | 28 ++
 rtl/bus_tx_framer.sv | 141 ++++++++++++++
 tb/tb_bus_tx_framer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/bus_tx_framer_if.sv
// Client-side channels of the bus send framer: payload FIFO write, frame request, send handshake.
// The master modport is the framer's view; slave is the client/bus-interface view.
interface bus_tx_framer_if #(
  parameter int unsigned LenW = 5
) ();
  logic            pl_valid;
  logic [7:0]      pl_data;
  logic            pl_ready;
  logic            req_valid;
  logic [1:0]      req_src;
  logic [1:0]      req_dst;
  logic [1:0]      req_op;
  logic [LenW-1:0] req_len;
  logic            req_ready;
  logic            send_valid;
  logic [7:0]      send_data;
  logic            send_ready;

  modport master (
    input  pl_valid, pl_data, req_valid, req_src, req_dst, req_op, req_len, send_ready,
    output pl_ready, req_ready, send_valid, send_data
  );

  modport slave (
    output pl_valid, pl_data, req_valid, req_src, req_dst, req_op, req_len, send_ready,
    input  pl_ready, req_ready, send_valid, send_data
  );
endinterface

// File: rtl/bus_tx_framer.sv
// Send-side framer: buffers payload in a FIFO, then emits a header byte plus len payload bytes
// on the send handshake and pulses ack. A stalled bus for Timeout cycles aborts and flushes.
module bus_tx_framer #(
  parameter int unsigned FifoDepth = 16,
  parameter int unsigned LenW      = 5,
  parameter int unsigned Timeout   = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  bus_tx_framer_if.master   bus,
  output logic              ack_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_timeout_o,
  output logic [LenW:0]     fifo_count_o
);

  localparam int unsigned PtrW   = $clog2(FifoDepth);
  localparam int unsigned CntW   = LenW + 1;
  localparam int unsigned StallW = $clog2(Timeout + 1);
  localparam logic [StallW-1:0] StallMax = StallW'(Timeout - 1);

  typedef enum logic [2:0] {StIdle, StHdr, StData, StAck, StAbrt, StFlush} state_e;

  state_e            state_q;
  logic [7:0]        hdr_q;
  logic [LenW-1:0]   rem_q;
  logic [StallW-1:0] stall_q;

  logic [7:0]        mem_q [FifoDepth];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q, count_d;

  logic full, push, pop, xfer, req_ready, req_fire;
  logic send_valid;
  logic [7:0] send_data;

  // pl_ready comes from the registered count only, so a pop never frees a slot in the same cycle
  assign full      = (count_q == CntW'(FifoDepth));
  assign push      = bus.pl_valid & ~full;
  assign xfer      = send_valid & bus.send_ready;
  assign pop       = ((state_q == StData) & xfer) | (state_q == StFlush);
  assign count_d   = count_q + CntW'(push) - CntW'(pop);
  assign req_ready = (state_q == StIdle) & (count_q >= {1'b0, bus.req_len});
  assign req_fire  = bus.req_valid & req_ready;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= bus.pl_data;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      hdr_q   <= '0;
      rem_q   <= '0;
      stall_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_fire) begin
            hdr_q   <= {bus.req_op, bus.req_dst, bus.req_src, 2'b00};
            rem_q   <= bus.req_len;
            stall_q <= '0;
            state_q <= StHdr;
          end
        end
        StHdr: begin
          if (bus.send_ready) begin
            stall_q <= '0;
            state_q <= (rem_q == '0) ? StAck : StData;
          end else if (stall_q == StallMax) begin
            stall_q <= '0;
            state_q <= StAbrt;
          end else begin
            stall_q <= stall_q + StallW'(1);
          end
        end
        StData: begin
          if (bus.send_ready) begin
            stall_q <= '0;
            rem_q   <= rem_q - LenW'(1);
            if (rem_q == LenW'(1)) state_q <= StAck;
          end else if (stall_q == StallMax) begin
            stall_q <= '0;
            state_q <= StAbrt;
          end else begin
            stall_q <= stall_q + StallW'(1);
          end
        end
        StAck:  state_q <= StIdle;
        StAbrt: state_q <= (rem_q == '0) ? StIdle : StFlush;
        StFlush: begin
          // Discard the unsent payload of the aborted frame
          rem_q <= rem_q - LenW'(1);
          if (rem_q == LenW'(1)) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    send_valid = 1'b0;
    send_data  = '0;
    case (state_q)
      StHdr: begin
        send_valid = 1'b1;
        send_data  = hdr_q;
      end
      StData: begin
        send_valid = 1'b1;
        send_data  = mem_q[rd_ptr_q];
      end
      default: ;
    endcase
  end

  assign bus.send_valid = send_valid;
  assign bus.send_data  = send_data;
  assign bus.pl_ready   = ~full;
  assign bus.req_ready  = req_ready;

  assign ack_o         = (state_q == StAck) | (state_q == StAbrt);
  assign done_o        = (state_q == StAck);
  assign err_timeout_o = (state_q == StAbrt);
  assign busy_o        = (state_q != StIdle);
  assign fifo_count_o  = count_q;

endmodule

// File: tb/tb_bus_tx_framer.sv
// Directed bench for bus_tx_framer with hand-computed headers, byte order and timeout behaviour.
module tb_bus_tx_framer;
  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       ack_o, busy_o, done_o, err_timeout_o;
  logic [5:0] fifo_count_o;

  int n_cmp = 0;
  int n_bad = 0;

  bus_tx_framer_if #(.LenW(5)) bus_if ();

  bus_tx_framer #(
    .FifoDepth(16),
    .LenW     (5),
    .Timeout  (4)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .bus          (bus_if),
    .ack_o        (ack_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_timeout_o(err_timeout_o),
    .fifo_count_o (fifo_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    bus_if.pl_valid = 1'b1;
    bus_if.pl_data  = d;
    step();
    bus_if.pl_valid = 1'b0;
  endtask

  task automatic request(input logic [1:0] src, input logic [1:0] dst, input logic [1:0] op,
                         input logic [4:0] len);
    bus_if.req_src   = src;
    bus_if.req_dst   = dst;
    bus_if.req_op    = op;
    bus_if.req_len   = len;
    bus_if.req_valid = 1'b1;
    #1;
    chk("req_ready_at_accept", 32'(bus_if.req_ready), 1);
    step();
    bus_if.req_valid = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_send_valid"}, 32'(bus_if.send_valid), 0);
    chk({tag, "_send_data"}, 32'(bus_if.send_data), 0);
    chk({tag, "_ack"}, 32'(ack_o), 0);
    chk({tag, "_busy"}, 32'(busy_o), 0);
    chk({tag, "_done"}, 32'(done_o), 0);
    chk({tag, "_err"}, 32'(err_timeout_o), 0);
    chk({tag, "_count"}, 32'(fifo_count_o), 0);
  endtask

  logic [7:0] exp4 [5];
  int         idx;

  initial begin
    bus_if.pl_valid   = 1'b0;
    bus_if.pl_data    = '0;
    bus_if.req_valid  = 1'b0;
    bus_if.req_src    = '0;
    bus_if.req_dst    = '0;
    bus_if.req_op     = '0;
    bus_if.req_len    = '0;
    bus_if.send_ready = 1'b0;
    exp4 = '{8'h70, 8'h55, 8'h66, 8'h77, 8'h88};

    // Reset
    step();
    step();
    chk_idle_outputs("rst_held");
    rst_i = 1'b0;
    step();
    chk_idle_outputs("rst_release");
    chk("rst_pl_ready", 32'(bus_if.pl_ready), 1);

    // 1) three-byte frame, bus always ready
    bus_if.send_ready = 1'b1;
    push(8'hA1);
    push(8'hB2);
    push(8'hC3);
    chk("t1_count_pre", 32'(fifo_count_o), 3);
    request(2'd1, 2'd2, 2'd3, 5'd3);
    chk("t1_hdr_valid", 32'(bus_if.send_valid), 1);
    chk("t1_hdr", 32'(bus_if.send_data), 32'hE4);
    chk("t1_busy", 32'(busy_o), 1);
    step();
    chk("t1_b0", 32'(bus_if.send_data), 32'hA1);
    step();
    chk("t1_b1", 32'(bus_if.send_data), 32'hB2);
    step();
    chk("t1_b2", 32'(bus_if.send_data), 32'hC3);
    chk("t1_b2_ack", 32'(ack_o), 0);
    step();
    chk("t1_ack", 32'(ack_o), 1);
    chk("t1_done", 32'(done_o), 1);
    chk("t1_ack_valid", 32'(bus_if.send_valid), 0);
    chk("t1_count_post", 32'(fifo_count_o), 0);
    step();
    chk("t1_ack_gone", 32'(ack_o), 0);
    chk("t1_idle", 32'(busy_o), 0);

    // 2) header-only frame leaves the FIFO alone
    push(8'h55);
    request(2'd2, 2'd1, 2'd0, 5'd0);
    chk("t2_hdr", 32'(bus_if.send_data), 32'h18);
    chk("t2_hdr_valid", 32'(bus_if.send_valid), 1);
    step();
    chk("t2_ack", 32'(ack_o), 1);
    chk("t2_done", 32'(done_o), 1);
    chk("t2_count", 32'(fifo_count_o), 1);
    step();
    chk("t2_idle", 32'(busy_o), 0);

    // 3) request waits until the payload is resident
    push(8'h66);
    bus_if.req_len = 5'd4;
    #1;
    chk("t3_cnt2", 32'(fifo_count_o), 2);
    chk("t3_rdy_cnt2", 32'(bus_if.req_ready), 0);
    push(8'h77);
    chk("t3_rdy_cnt3", 32'(bus_if.req_ready), 0);
    push(8'h88);
    chk("t3_cnt4", 32'(fifo_count_o), 4);
    chk("t3_rdy_cnt4", 32'(bus_if.req_ready), 1);

    // 4) send_ready pattern 1,0,0 repeating: bytes held while stalled, order preserved
    request(2'd0, 2'd3, 2'd1, 5'd4);
    idx = 0;
    for (int c = 0; c < 40 && idx < 5; c++) begin
      chk("t4_valid", 32'(bus_if.send_valid), 1);
      chk("t4_data", 32'(bus_if.send_data), 32'(exp4[idx]));
      bus_if.send_ready = (c % 3 == 0);
      step();
      if (c % 3 == 0) idx++;
    end
    bus_if.send_ready = 1'b1;
    chk("t4_nbytes", 32'(idx), 5);
    chk("t4_ack", 32'(ack_o), 1);
    chk("t4_done", 32'(done_o), 1);
    chk("t4_count", 32'(fifo_count_o), 0);
    step();

    // 5) stall after header: abort after 4 stalled cycles, then flush 3 bytes
    push(8'h01);
    push(8'h02);
    push(8'h03);
    request(2'd1, 2'd1, 2'd1, 5'd3);
    chk("t5_hdr", 32'(bus_if.send_data), 32'h54);
    step();
    bus_if.send_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("t5_stall_valid", 32'(bus_if.send_valid), 1);
      chk("t5_stall_data", 32'(bus_if.send_data), 32'h01);
      chk("t5_stall_noack", 32'(ack_o), 0);
      step();
    end
    chk("t5_ack", 32'(ack_o), 1);
    chk("t5_err", 32'(err_timeout_o), 1);
    chk("t5_done", 32'(done_o), 0);
    chk("t5_abrt_valid", 32'(bus_if.send_valid), 0);
    chk("t5_abrt_count", 32'(fifo_count_o), 3);
    step();
    chk("t5_flush_ack", 32'(ack_o), 0);
    chk("t5_flush_busy", 32'(busy_o), 1);
    chk("t5_flush_count", 32'(fifo_count_o), 3);
    step();
    step();
    step();
    chk("t5_end_count", 32'(fifo_count_o), 0);
    chk("t5_end_idle", 32'(busy_o), 0);
    bus_if.send_ready = 1'b1;

    // 6) fill to full, blocked write at full, write+pop balance, reset mid-frame
    for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
    chk("t6_full_count", 32'(fifo_count_o), 16);
    chk("t6_full_plready", 32'(bus_if.pl_ready), 0);
    push(8'hEE);
    chk("t6_blocked_count", 32'(fifo_count_o), 16);
    request(2'd3, 2'd0, 2'd2, 5'd5);
    chk("t6_hdr", 32'(bus_if.send_data), 32'h8C);
    step();
    chk("t6_b0", 32'(bus_if.send_data), 32'h10);
    bus_if.pl_valid = 1'b1;
    bus_if.pl_data  = 8'hEE;
    step();
    chk("t6_pop_blocked_wr", 32'(fifo_count_o), 15);
    chk("t6_b1", 32'(bus_if.send_data), 32'h11);
    bus_if.pl_data = 8'h20;
    step();
    bus_if.pl_valid = 1'b0;
    chk("t6_wr_and_pop", 32'(fifo_count_o), 15);
    chk("t6_b2", 32'(bus_if.send_data), 32'h12);
    step();
    chk("t6_b3", 32'(bus_if.send_data), 32'h13);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk_idle_outputs("t6_rst");
    step();
    chk("t6_no_ack", 32'(ack_o), 0);
    chk("t6_pl_ready", 32'(bus_if.pl_ready), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
